// File: rtl/window_rd_seq.sv
// Read-side sequencer for the convolution window register file: walks slots
// 0..WINDOW_REG_SIZE-1 and streams them over a registered valid/ready port.
module window_rd_seq #(
  parameter int WINDOW_ELEMNT_SIZE = 8,
  parameter int WINDOW_REG_SIZE    = 9,
  parameter int ADDR_SIZE          = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic [ADDR_SIZE-1:0]          rd_addr,
  input  logic [WINDOW_ELEMNT_SIZE-1:0] rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WINDOW_ELEMNT_SIZE-1:0] m_data,
  output logic [ADDR_SIZE-1:0]          m_index,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(WINDOW_REG_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] END_IDX  = ADDR_SIZE'(WINDOW_REG_SIZE);

  state_t                          state, state_d;
  logic [ADDR_SIZE-1:0]            idx, idx_d;
  logic                            valid_d, last_d;
  logic [WINDOW_ELEMNT_SIZE-1:0]   data_d;
  logic [ADDR_SIZE-1:0]            index_d;
  logic                            xfer;
  logic                            load;

  assign rd_addr = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  assign xfer = m_valid && m_ready;
  // The output slot is free when empty or being drained this very edge.
  assign load = (state == STREAM) && (idx < END_IDX) && (!m_valid || m_ready);

  always_comb begin
    // NOTE: every signal driven here gets a hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state;
    idx_d   = idx;
    valid_d = m_valid;
    data_d  = m_data;
    index_d = m_index;
    last_d  = m_last;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end

      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (xfer && m_last) begin
          state_d = DONE;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (load) begin
          data_d  = rd_data;
          index_d = idx;
          last_d  = (idx == LAST_IDX);
          valid_d = 1'b1;
          idx_d   = idx + 1'b1;
        end else if (xfer) begin
          valid_d = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears every register, including the output
  // data/index, so the stream port reads all-zero immediately on assertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state   <= state_d;
      idx     <= idx_d;
      m_valid <= valid_d;
      m_data  <= data_d;
      m_index <= index_d;
      m_last  <= last_d;
    end
  end

endmodule
